// File: rtl/line_pingpong_buffer.sv
// Two-bank line store: one bank captures a data_valid burst while the other
// streams the previous line out over valid/ready with per-line pixel and DSI word counts.
module line_pingpong_buffer #(
    parameter int PIXEL_W   = 24,
    parameter int DEPTH     = 1024,
    parameter int BPP_BYTES = 3,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               data_valid,
    output logic [PIXEL_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [CNT_W-1:0]   line_pixels,
    output logic [15:0]        line_wc,
    output logic               overflow_err,
    output logic               drop_pulse,
    output logic [7:0]         drop_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_FILL    = 2'd1,
        W_DISCARD = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_SEND = 1'b1
    } rd_state_t;

    logic [PIXEL_W-1:0] r_mem [2][DEPTH];

    wr_state_t          r_wr_state;
    logic               r_wr_bank;
    logic [CNT_W-1:0]   r_wr_ptr;
    logic               r_guard;
    logic               r_overflow;
    logic               r_drop_pulse;
    logic [7:0]         r_drop_count;

    logic [1:0]         r_full;
    logic [CNT_W-1:0]   r_count [2];

    rd_state_t          r_rd_state;
    logic               r_rd_bank;
    logic [CNT_W-1:0]   r_rd_ptr;
    logic [PIXEL_W-1:0] r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic [CNT_W-1:0]   r_line_pixels;
    logic [15:0]        r_line_wc;

    logic               w_rd_done;
    logic               w_commit;
    logic               w_wr_free;
    logic               w_start;
    logic               w_fill_we;
    logic               w_mem_we;
    logic [AW-1:0]      w_mem_addr;
    logic [CNT_W-1:0]   w_rd_cnt;
    logic [CNT_W-1:0]   w_rd_next;
    logic [15:0]        w_wc;

    // A bank whose last pixel is handshaken this cycle is already free for a new line.
    assign w_rd_done  = (r_rd_state == R_SEND) && r_out_valid && out_ready && r_out_last;
    assign w_commit   = (r_wr_state == W_FILL) && !data_valid;
    assign w_wr_free  = !r_full[r_wr_bank] || (w_rd_done && (r_rd_bank == r_wr_bank));
    assign w_start    = (r_wr_state == W_IDLE) && !r_guard && data_valid && w_wr_free;
    assign w_fill_we  = (r_wr_state == W_FILL) && data_valid && (r_wr_ptr < DEPTH_C);
    assign w_mem_we   = w_start || w_fill_we;
    assign w_mem_addr = w_start ? {AW{1'b0}} : r_wr_ptr[AW-1:0];
    assign w_rd_cnt   = r_count[r_rd_bank];
    assign w_rd_next  = r_rd_ptr + ONE_C;
    assign w_wc       = 16'(32'(w_rd_cnt) * 32'(BPP_BYTES));

    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign line_pixels  = r_line_pixels;
    assign line_wc      = r_line_wc;
    assign overflow_err = r_overflow;
    assign drop_pulse   = r_drop_pulse;
    assign drop_count   = r_drop_count;

    // Pixel storage; contents are don't-care after reset.
    always_ff @(posedge pclk) begin
        if (w_mem_we) begin
            r_mem[r_wr_bank][w_mem_addr] <= pixel_data;
        end
    end

    // Writer: capture, overflow clipping, whole-line drops and the post-reset guard.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_wr_state   <= W_IDLE;
            r_wr_bank    <= 1'b0;
            r_wr_ptr     <= {CNT_W{1'b0}};
            r_guard      <= 1'b1;
            r_overflow   <= 1'b0;
            r_drop_pulse <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            r_drop_pulse <= 1'b0;
            case (r_wr_state)
                W_IDLE: begin
                    r_wr_ptr <= {CNT_W{1'b0}};
                    if (r_guard) begin
                        if (!data_valid) begin
                            r_guard <= 1'b0;
                        end
                    end else if (data_valid) begin
                        if (w_wr_free) begin
                            r_wr_ptr   <= ONE_C;
                            r_wr_state <= W_FILL;
                        end else begin
                            r_wr_state <= W_DISCARD;
                        end
                    end
                end
                W_FILL: begin
                    if (data_valid) begin
                        if (r_wr_ptr < DEPTH_C) begin
                            r_wr_ptr <= r_wr_ptr + ONE_C;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end else begin
                        r_wr_bank  <= ~r_wr_bank;
                        r_wr_state <= W_IDLE;
                    end
                end
                W_DISCARD: begin
                    if (!data_valid) begin
                        r_drop_pulse <= 1'b1;
                        if (r_drop_count != 8'hFF) begin
                            r_drop_count <= r_drop_count + 8'd1;
                        end
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // Bank ownership: set by the writer on commit, cleared by the reader after the last pixel.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_full     <= 2'b00;
            r_count[0] <= {CNT_W{1'b0}};
            r_count[1] <= {CNT_W{1'b0}};
        end else begin
            if (w_commit) begin
                r_full[r_wr_bank]  <= 1'b1;
                r_count[r_wr_bank] <= r_wr_ptr;
            end
            if (w_rd_done) begin
                r_full[r_rd_bank] <= 1'b0;
            end
        end
    end

    // Reader: presents one pixel per handshake and holds everything during stalls.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_rd_state    <= R_IDLE;
            r_rd_bank     <= 1'b0;
            r_rd_ptr      <= {CNT_W{1'b0}};
            r_out_data    <= {PIXEL_W{1'b0}};
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_line_pixels <= {CNT_W{1'b0}};
            r_line_wc     <= 16'd0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_rd_state    <= R_SEND;
                        r_rd_ptr      <= {CNT_W{1'b0}};
                        r_out_data    <= r_mem[r_rd_bank][{AW{1'b0}}];
                        r_out_valid   <= 1'b1;
                        r_out_last    <= (w_rd_cnt == ONE_C);
                        r_line_pixels <= w_rd_cnt;
                        r_line_wc     <= w_wc;
                    end
                end
                R_SEND: begin
                    if (r_out_valid && out_ready) begin
                        if (r_out_last) begin
                            r_rd_bank   <= ~r_rd_bank;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_rd_state  <= R_IDLE;
                        end else begin
                            r_rd_ptr   <= w_rd_next;
                            r_out_data <= r_mem[r_rd_bank][w_rd_next[AW-1:0]];
                            r_out_last <= (w_rd_next == (w_rd_cnt - ONE_C));
                        end
                    end
                end
                default: begin
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_pingpong_buffer.sv
// Randomised and directed bench for line_pingpong_buffer, scored against a
// queue-based line model that predicts every output each cycle.
module tb_line_pingpong_buffer;

    localparam int PW    = 24;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          pclk;
    logic          rst;
    logic [PW-1:0] pixel_data;
    logic          data_valid;
    logic [PW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [CW-1:0] line_pixels;
    logic [15:0]   line_wc;
    logic          overflow_err;
    logic          drop_pulse;
    logic [7:0]    drop_count;

    line_pingpong_buffer #(.PIXEL_W(PW), .DEPTH(DEPTH), .BPP_BYTES(3)) dut (
        .pclk(pclk), .rst(rst), .pixel_data(pixel_data), .data_valid(data_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .line_pixels(line_pixels), .line_wc(line_wc),
        .overflow_err(overflow_err), .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Line model: committed pixels in capture order plus one length per buffered line.
    logic [PW-1:0] m_pix [$];
    int            m_len [$];
    logic [PW-1:0] m_fill [$];
    int  m_ws;      // 0 idle, 1 capturing, 2 discarding
    bit  m_guard;
    bit  m_valid;
    int  m_pos;
    int  m_lp, m_wc, m_dcnt;
    bit  m_ovf, m_dpulse;

    int            rdy_mode;
    bit            tgl;
    logic [PW-1:0] seq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pix.delete(); m_len.delete(); m_fill.delete();
        m_ws = 0; m_guard = 1'b1; m_valid = 1'b0; m_pos = 0;
        m_lp = 0; m_wc = 0; m_dcnt = 0; m_ovf = 1'b0; m_dpulse = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit dv, input logic [PW-1:0] px, input bit rd);
        bit hs, last;
        int occ;
        if (r) begin
            model_reset();
            return;
        end
        hs   = m_valid && rd;
        last = 1'b0;
        if (hs) last = (m_pos == m_len[0] - 1);
        occ = m_len.size() - (last ? 1 : 0);
        m_dpulse = 1'b0;
        if (m_valid) begin
            if (hs) begin
                if (last) begin
                    repeat (m_len[0]) void'(m_pix.pop_front());
                    void'(m_len.pop_front());
                    m_valid = 1'b0;
                end else begin
                    m_pos++;
                end
            end
        end else if (m_len.size() > 0) begin
            m_valid = 1'b1;
            m_pos   = 0;
            m_lp    = m_len[0];
            m_wc    = (m_len[0] * 3) & 32'hFFFF;
        end
        case (m_ws)
            0: begin
                if (m_guard) begin
                    if (!dv) m_guard = 1'b0;
                end else if (dv) begin
                    if (occ < 2) begin
                        m_fill.delete();
                        m_fill.push_back(px);
                        m_ws = 1;
                    end else begin
                        m_ws = 2;
                    end
                end
            end
            1: begin
                if (dv) begin
                    if (m_fill.size() < DEPTH) m_fill.push_back(px);
                    else m_ovf = 1'b1;
                end else begin
                    foreach (m_fill[i]) m_pix.push_back(m_fill[i]);
                    m_len.push_back(m_fill.size());
                    m_ws = 0;
                end
            end
            default: begin
                if (!dv) begin
                    m_dpulse = 1'b1;
                    if (m_dcnt < 255) m_dcnt++;
                    m_ws = 0;
                end
            end
        endcase
    endtask

    task automatic compare_outputs();
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check_eq("out_data", 32'(out_data), 32'(m_pix[m_pos]));
            check_eq("out_last", 32'(out_last), 32'(m_pos == m_len[0] - 1));
        end else begin
            check_eq("out_last_idle", 32'(out_last), 32'd0);
        end
        check_eq("line_pixels", 32'(line_pixels), 32'(m_lp));
        check_eq("line_wc", 32'(line_wc), 32'(m_wc));
        check_eq("overflow_err", 32'(overflow_err), 32'(m_ovf));
        check_eq("drop_pulse", 32'(drop_pulse), 32'(m_dpulse));
        check_eq("drop_count", 32'(drop_count), 32'(m_dcnt));
    endtask

    function automatic bit pick_rdy();
        case (rdy_mode)
            0: return 1'b0;
            1: return 1'b1;
            2: begin tgl = ~tgl; return tgl; end
            default: return ($urandom_range(0, 9) < 7);
        endcase
    endfunction

    task automatic tick(input bit r, input bit dv, input logic [PW-1:0] px, input bit rd);
        @(negedge pclk);
        compare_outputs();
        rst = r; data_valid = dv; pixel_data = px; out_ready = rd;
        model_step(r, dv, px, rd);
    endtask

    task automatic send_line(input int n, input int gap, input bit rand_px);
        logic [PW-1:0] px;
        for (int i = 0; i < n; i++) begin
            if (rand_px) px = PW'($urandom);
            else begin px = seq; seq = seq + 24'd1; end
            tick(1'b0, 1'b1, px, pick_rdy());
        end
        for (int i = 0; i < gap; i++) tick(1'b0, 1'b0, 24'd0, pick_rdy());
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((m_valid || m_len.size() > 0 || m_ws != 0) && k < 300) begin
            tick(1'b0, 1'b0, 24'd0, pick_rdy());
            k++;
        end
        check_eq("drain_timeout", 32'(k >= 300), 32'd0);
        tick(1'b0, 1'b0, 24'd0, 1'b1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 24'd0, 1'b0);
        tick(1'b0, 1'b0, 24'd0, 1'b0);
    endtask

    initial begin
        int k;
        rst = 1'b1; data_valid = 1'b0; pixel_data = '0; out_ready = 1'b0;
        tgl = 1'b0; seq = 24'd1;
        model_reset();
        do_reset();

        // single 8-pixel line with the consumer always ready
        rdy_mode = 1;
        send_line(8, 1, 1'b0);
        drain();
        check_eq("single_lp", 32'(line_pixels), 32'd8);
        check_eq("single_wc", 32'(line_wc), 32'd24);

        // two short lines back-to-back under toggling backpressure
        rdy_mode = 2;
        send_line(4, 1, 1'b0);
        send_line(4, 1, 1'b0);
        drain();

        // overflow line, then clear the sticky flag with reset
        rdy_mode = 1;
        send_line(20, 1, 1'b0);
        drain();
        check_eq("ovf_lp", 32'(line_pixels), 32'd16);
        check_eq("ovf_wc", 32'(line_wc), 32'd48);
        check_eq("ovf_flag", 32'(overflow_err), 32'd1);
        do_reset();
        check_eq("ovf_cleared", 32'(overflow_err), 32'd0);

        // three lines against a stalled consumer: the third is dropped
        rdy_mode = 0;
        send_line(4, 1, 1'b0);
        send_line(4, 1, 1'b0);
        send_line(4, 2, 1'b0);
        check_eq("drop_cnt", 32'(drop_count), 32'd1);
        rdy_mode = 1;
        drain();

        // new line starts on the same edge as the final handshake of a full bank
        rdy_mode = 0;
        send_line(4, 1, 1'b0);
        send_line(4, 1, 1'b0);
        k = 0;
        while (!(m_valid && m_pos == m_len[0] - 1) && k < 40) begin
            tick(1'b0, 1'b0, 24'd0, 1'b1);
            k++;
        end
        check_eq("simfree_reach", 32'(k >= 40), 32'd0);
        rdy_mode = 1;
        send_line(4, 1, 1'b0);
        drain();
        check_eq("simfree_nodrop", 32'(drop_count), 32'd1);

        // reset in the middle of a line with data_valid still high afterwards
        tick(1'b0, 1'b1, 24'hA1, 1'b1);
        tick(1'b0, 1'b1, 24'hA2, 1'b1);
        tick(1'b1, 1'b1, 24'hA3, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 24'hB0 + 24'(i), 1'b1);
        check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid_dcnt", 32'(drop_count), 32'd0);
        tick(1'b0, 1'b0, 24'd0, 1'b1);
        send_line(6, 1, 1'b0);
        drain();
        check_eq("rst_mid_lp", 32'(line_pixels), 32'd6);

        // randomised traffic
        rdy_mode = 3;
        for (int l = 0; l < 40; l++) begin
            send_line($urandom_range(1, 20), $urandom_range(1, 3), 1'b1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
